hbm_val_rd_arbiter: RTL and testbench

- Shares the single HBM Val AXI4 read channel of spmv_calc_top among CONF_NUM_KERNEL kernel read masters.
- Round-robin arbitration on the AR channel.
- An in-order grant FIFO routes R beats back to the requester that owns each burst.
- Sits between the per-kernel Val fetch engines and the m_axi_hbm_Val_* port. The write channels are not handled here.

---
 rtl/spmv_pkg.sv | 13 +
 rtl/hbm_val_order_fifo.sv | 50 +++++
 rtl/hbm_val_rd_arbiter.sv | 156 +++++++++++++++
 tb/tb_hbm_val_rd_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared SpMV constants and types: HBM channel widths, AXI encodings and the
// read-arbiter FSM state type.
package spmv_pkg;

  localparam int unsigned HBM_ADDR_W = 48;
  localparam int unsigned HBM_DATA_W = 256;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic {IDLE, HOLD} arb_state_t;

endpackage

// File: rtl/hbm_val_order_fifo.sv
// In-order record of which requester owns each outstanding HBM Val read burst.
// Depth MAX_OUTST (power of 2); the count spans 0..MAX_OUTST inclusive.
module hbm_val_order_fifo #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUTST = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            push,
  input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] push_data,
  input  logic                                            pop,
  output logic                                            full,
  output logic                                            empty,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] head
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);

  logic [IDX_W-1:0] mem [MAX_OUTST];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(MAX_OUTST));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/hbm_val_rd_arbiter.sv
// Round-robin sharing of the HBM Val AXI4 read channel among NUM_REQ kernels.
// Optional VAL_ARB_PERF_EN adds per-requester grant counters and a stall counter.
module hbm_val_rd_arbiter
  import spmv_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = HBM_ADDR_W,
  parameter int unsigned DATA_W    = HBM_DATA_W,
  parameter int unsigned MAX_OUTST = 16
) (
  input  logic                      axis_clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]      s_arlen,
  input  logic [NUM_REQ*3-1:0]      s_arsize,
  input  logic [NUM_REQ*2-1:0]      s_arburst,
  input  logic [NUM_REQ-1:0]        s_arvalid,
  output logic [NUM_REQ-1:0]        s_arready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic [NUM_REQ-1:0]        s_rvalid,
  input  logic [NUM_REQ-1:0]        s_rready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
`ifdef VAL_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]     perf_grant_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] last_win;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             grant;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  logic             rd_pop;
  int unsigned      cand;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && s_arvalid[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant = (state == IDLE) && win_found && !fifo_full;

  always_comb begin
    s_arready = '0;
    if (grant) s_arready[win_idx] = 1'b1;
  end

  always_ff @(posedge axis_clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      last_win  <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            m_araddr  <= s_araddr[win_idx*ADDR_W +: ADDR_W];
            m_arlen   <= s_arlen[win_idx*8 +: 8];
            m_arsize  <= s_arsize[win_idx*3 +: 3];
            m_arburst <= s_arburst[win_idx*2 +: 2];
            m_arvalid <= 1'b1;
            last_win  <= win_idx;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            ptr       <= (last_win == IDX_W'(NUM_REQ-1)) ? '0 : last_win + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  hbm_val_order_fifo #(
    .NUM_REQ   (NUM_REQ),
    .MAX_OUTST (MAX_OUTST)
  ) u_order_fifo (
    .clk       (axis_clk),
    .rst       (rst),
    .push      (grant),
    .push_data (win_idx),
    .pop       (rd_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // R beats go only to the owner of the oldest outstanding burst.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b0;
    if (!fifo_empty) begin
      s_rvalid[fifo_head] = m_rvalid;
      m_rready            = s_rready[fifo_head];
    end
  end

  assign rd_pop  = m_rvalid && m_rready && m_rlast;
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

`ifdef VAL_ARB_PERF_EN
  always_ff @(posedge axis_clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (grant)
        perf_grant_cnt[win_idx*32 +: 32] <= perf_grant_cnt[win_idx*32 +: 32] + 32'd1;
      if (|s_arvalid && fifo_full)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hbm_val_rd_arbiter.sv
// Self-checking bench for hbm_val_rd_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_hbm_val_rd_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned MO = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [N-1:0]    s_arvalid;
  logic [N-1:0]    s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [N-1:0]    s_rvalid;
  logic [N-1:0]    s_rready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;
`ifdef VAL_ARB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  hbm_val_rd_arbiter #(
    .NUM_REQ   (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_OUTST (MO)
  ) dut (
    .axis_clk  (clk),
    .rst       (rst),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
`ifdef VAL_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: busy flag for the pending master AR, owner queue for R routing.
  bit          md_busy;
  int unsigned md_ptr;
  int unsigned md_last;
  int          md_q[$];
  logic [60:0] md_ar;
  int unsigned md_gcnt[N];
  int unsigned md_stall;

  function automatic int model_winner();
    int unsigned c;
    if (md_busy || md_q.size() >= MO) return -1;
    for (int unsigned k = 0; k < N; k++) begin
      c = (md_ptr + k) % N;
      if (s_arvalid[c]) return int'(c);
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int       w;
    logic [N-1:0] e_ar;
    logic [N-1:0] e_rv;
    logic     e_rr;
    w = model_winner();
    if (chk_en) begin
      e_ar = '0;
      if (w >= 0) e_ar[w] = 1'b1;
      chk("s_arready", 64'(s_arready), 64'(e_ar));
      chk("m_arvalid", 64'(m_arvalid), 64'(md_busy));
      if (md_busy) chk("m_ar_fields", 64'({m_araddr, m_arlen, m_arsize, m_arburst}), 64'(md_ar));
      e_rv = '0;
      e_rr = 1'b0;
      if (md_q.size() > 0) begin
        e_rv[md_q[0]] = m_rvalid;
        e_rr          = s_rready[md_q[0]];
      end
      chk("s_rvalid", 64'(s_rvalid), 64'(e_rv));
      chk("m_rready", 64'(m_rready), 64'(e_rr));
      chk("s_rdata", s_rdata, m_rdata);
      chk("s_rresp_rlast", 64'({s_rresp, s_rlast}), 64'({m_rresp, m_rlast}));
`ifdef VAL_ARB_PERF_EN
      for (int unsigned i = 0; i < N; i++)
        chk("perf_grant_cnt", 64'(perf_grant_cnt[i*32 +: 32]), 64'(md_gcnt[i]));
      chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(md_stall));
`endif
    end
    if (rst) begin
      md_busy  = 1'b0;
      md_ptr   = 0;
      md_last  = 0;
      md_q.delete();
      md_stall = 0;
      for (int unsigned i = 0; i < N; i++) md_gcnt[i] = 0;
    end else begin
      if (|s_arvalid && md_q.size() >= MO) md_stall++;
      if (md_q.size() > 0 && m_rvalid && m_rlast && s_rready[md_q[0]]) void'(md_q.pop_front());
      if (w >= 0) begin
        md_busy = 1'b1;
        md_ar   = {s_araddr[w*AW +: AW], s_arlen[w*8 +: 8], s_arsize[w*3 +: 3], s_arburst[w*2 +: 2]};
        md_q.push_back(w);
        md_last = w;
        md_gcnt[w]++;
      end else if (md_busy && m_arready) begin
        md_busy = 1'b0;
        md_ptr  = (md_last + 1) % N;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    m_rvalid  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic set_ar(input int unsigned i, input logic [AW-1:0] a, input logic [7:0] len);
    s_araddr[i*AW +: AW] = a;
    s_arlen[i*8 +: 8]    = len;
    s_arsize[i*3 +: 3]   = 3'd5;
    s_arburst[i*2 +: 2]  = 2'b01;
  endtask

  // Bounded wait for the next grant; returns 0 on timeout so the caller's check fails.
  task automatic collect_grant(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_arready != '0) begin
        g = s_arready;
        nxt();
        return;
      end
      nxt();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] fair_exp [5];
    int           n_gr;
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    clear_inputs();
    rst = 1'b1;
    nxt();
    nxt();
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("reset_m_araddr", 64'(m_araddr), 64'd0);
    chk("reset_s_arready", 64'(s_arready), 64'd0);
    nxt();

    // Single requester burst
    s_rready = '1;
    set_ar(1, 48'h1000, 8'd3);
    s_arvalid = 4'b0010;
    @(negedge clk);
    chk("t1_grant", 64'(s_arready), 64'b0010);
    nxt();
    s_arvalid = '0;
    @(negedge clk);
    chk("t1_arvalid", 64'(m_arvalid), 64'd1);
    chk("t1_araddr", 64'(m_araddr), 64'h1000);
    chk("t1_arlen", 64'(m_arlen), 64'd3);
    chk("t1_no_regrant", 64'(s_arready), 64'd0);
    nxt();
    m_arready = 1'b1;
    nxt();
    m_arready = 1'b0;
    @(negedge clk);
    chk("t1_arvalid_clr", 64'(m_arvalid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rlast  = (b == 3);
      m_rdata  = 64'(b + 16'hA0);
      @(negedge clk);
      chk("t1_beat_rvalid", 64'(s_rvalid), 64'b0010);
      chk("t1_beat_rready", 64'(m_rready), 64'd1);
      nxt();
    end
    m_rlast = 1'b0;
    @(negedge clk);
    chk("t1_empty_rvalid", 64'(s_rvalid), 64'd0);
    chk("t1_empty_rready", 64'(m_rready), 64'd0);
    nxt();

    // Fairness: all requesters, one grant every 2 cycles
    do_reset();
    s_arvalid = '1;
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    s_rready  = '1;
    n_gr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_arready != '0) begin
        if (n_gr < 5) begin
          chk("fair_order", 64'(s_arready), 64'(fair_exp[n_gr]));
          chk("fair_cycle", 64'(c), 64'(2 * n_gr));
        end
        n_gr++;
      end
      nxt();
    end
    chk("fair_count", 64'(n_gr), 64'd5);

    // Rotation
    do_reset();
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    s_rready  = '1;
    s_arvalid = 4'b1100;
    collect_grant(g);
    chk("rot_first", 64'(g), 64'b0100);
    collect_grant(g);
    chk("rot_second", 64'(g), 64'b1000);
    s_arvalid = 4'b0101;
    collect_grant(g);
    chk("rot_wrap", 64'(g), 64'b0001);

    // FIFO full, then drain one and reset during HOLD with two outstanding
    do_reset();
    m_arready = 1'b1;
    s_arvalid = 4'b0111;
    n_gr = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_arready != '0) n_gr++;
      if (c == 7) chk("full_no_grant", 64'(s_arready), 64'd0);
      nxt();
    end
    chk("full_grant_count", 64'(n_gr), 64'd2);
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    s_rready = '1;
    @(negedge clk);
    chk("full_pop_cycle", 64'(s_arready), 64'd0);
    nxt();
    m_rvalid = 1'b0;
    @(negedge clk);
    chk("full_third", 64'(s_arready), 64'b0100);
    nxt();
    m_arready = 1'b0;
    @(negedge clk);
    chk("hold_arvalid", 64'(m_arvalid), 64'd1);
    nxt();
    rst       = 1'b1;
    s_arvalid = '1;
    m_rvalid  = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rready", 64'(m_rready), 64'd0);
    chk("rst_ptr_grant", 64'(s_arready), 64'b0001);
`ifdef VAL_ARB_PERF_EN
    chk("rst_perf_grant", 64'(perf_grant_cnt), 64'd0);
    chk("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    nxt();

    // Backpressure and ordering: req0 then req2
    do_reset();
    m_arready = 1'b1;
    s_arvalid = 4'b0101;
    collect_grant(g);
    chk("bp_grant0", 64'(g), 64'b0001);
    collect_grant(g);
    chk("bp_grant2", 64'(g), 64'b0100);
    s_arvalid = '0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b0;
    s_rready  = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rready", 64'(m_rready), 64'd0);
      chk("bp_rvalid", 64'(s_rvalid), 64'b0001);
      nxt();
    end
    s_rready = '1;
    m_rlast  = 1'b1;
    @(negedge clk);
    chk("bp_last0", 64'(s_rvalid), 64'b0001);
    nxt();
    @(negedge clk);
    chk("bp_next2", 64'(s_rvalid), 64'b0100);
    nxt();

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int unsigned i = 0; i < N; i++)
        set_ar(i, {16'($urandom), 32'($urandom)}, 8'($urandom));
      s_arburst = N*2'($urandom);
      s_arsize  = N*3'($urandom);
      s_arvalid = N'($urandom);
      s_rready  = N'($urandom | $urandom);
      m_arready = ($urandom_range(0, 2) != 0);
      m_rvalid  = ($urandom_range(0, 2) != 0);
      m_rlast   = ($urandom_range(0, 2) == 0);
      m_rresp   = 2'($urandom);
      m_rdata   = {$urandom, $urandom};
      nxt();
    end

    rst = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
